// File: rtl/reg_alu_pkg.sv
// Shared ALU opcodes and a width-generic ALU function for the register-file/ALU datapath.
package reg_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Widest datapath the shared ALU function supports.
    localparam int ALU_MAXW = 64;

    typedef logic [ALU_MAXW:0] alu_word_t;

    // Returns {cout, res} packed into bits [width:0]; all higher bits are zero,
    // so a caller can take exactly width+1 bits with a size cast.
    // SUB is a + ~b + 1, so cout is the no-borrow flag.
    function automatic alu_word_t alu_f(
        input logic [1:0]          op,
        input logic [ALU_MAXW-1:0] a,
        input logic [ALU_MAXW-1:0] b,
        input logic [6:0]          width
    );
        alu_word_t mask;
        alu_word_t ea;
        alu_word_t eb;
        alu_word_t r;
        mask = (alu_word_t'(1) << width) - alu_word_t'(1);
        ea   = {1'b0, a} & mask;
        eb   = {1'b0, b} & mask;
        case (op)
            OP_ADD:  r = ea + eb;
            OP_SUB:  r = ea + (~eb & mask) + alu_word_t'(1);
            OP_AND:  r = ea & eb;
            default: r = ea | eb;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_alu_pipe_if.sv
// Issue/result bundle between the control unit (master) and the datapath core (slave).
interface reg_alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    // valid_in is a one-way issue strobe: there is no ready, the core accepts an op
    // on every rising edge where valid_in=1. result_valid marks that the EX stage
    // holds the op issued at the previous edge; result/cout/zero hold when it is 0.
    logic             valid_in;
    logic             sel;
    logic             wr;
    logic [1:0]       op;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out_a;
    logic [WIDTH-1:0] d_out_b;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             cout;
    logic             zero;

    modport master (
        output valid_in, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        input  d_out_a, d_out_b, result, result_valid, cout, zero
    );

    modport slave (
        input  valid_in, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        output d_out_a, d_out_b, result, result_valid, cout, zero
    );

endinterface

// File: rtl/reg_alu_pipe_reg_file.sv
// NREGS x WIDTH register file: async-reset, one write port, two combinational read ports.
module reg_file_p #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wd;
        end
    end

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];

endmodule

// File: rtl/reg_alu_pipe.sv
// Register-file/ALU datapath core: one op issues per cycle into a registered EX stage
// that writes back on the following edge, with optional EX->operand bypass.
module reg_alu_pipe
    import reg_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset,
    reg_alu_pipe_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic             ex_valid;
    logic             ex_we;
    logic [AW-1:0]    ex_addr;
    logic [WIDTH-1:0] ex_res;
    logic             ex_cout;
    logic             ex_zero;

    logic [WIDTH-1:0] file_a;
    logic [WIDTH-1:0] file_b;
    logic             byp_a;
    logic             byp_b;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH:0]   alu_out;
    logic [WIDTH-1:0] wb_data;
    logic             wb_cout;

    reg_file_p #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (ex_valid && ex_we),
        .wr_addr (ex_addr),
        .wd      (ex_res),
        .ra_a    (bus.rd_addr_a),
        .ra_b    (bus.rd_addr_b),
        .rd_a    (file_a),
        .rd_b    (file_b)
    );

    // The EX op has not reached the file yet, so a matching read takes it from EX.
    assign byp_a  = (BYPASS != 0) && ex_valid && ex_we && (ex_addr == bus.rd_addr_a);
    assign byp_b  = (BYPASS != 0) && ex_valid && ex_we && (ex_addr == bus.rd_addr_b);
    assign opnd_a = byp_a ? ex_res : file_a;
    assign opnd_b = byp_b ? ex_res : file_b;

    assign alu_out = (WIDTH + 1)'(alu_f(bus.op, ALU_MAXW'(opnd_a), ALU_MAXW'(opnd_b), 7'(WIDTH)));
    assign wb_data = bus.sel ? alu_out[WIDTH-1:0] : bus.d_in;
    assign wb_cout = bus.sel ? alu_out[WIDTH] : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_addr  <= '0;
            ex_res   <= '0;
            ex_cout  <= 1'b0;
            ex_zero  <= 1'b0;
        end else if (bus.valid_in) begin
            ex_valid <= 1'b1;
            ex_we    <= bus.wr;
            ex_addr  <= bus.wr_addr;
            ex_res   <= wb_data;
            ex_cout  <= wb_cout;
            ex_zero  <= (wb_data == '0);
        end else begin
            // Idle edge: the previous op has just written back; result and flags hold.
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
        end
    end

    assign bus.d_out_a      = opnd_a;
    assign bus.d_out_b      = opnd_b;
    assign bus.result       = ex_res;
    assign bus.result_valid = ex_valid;
    assign bus.cout         = ex_cout;
    assign bus.zero         = ex_zero;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Scoreboard bench: drives a BYPASS=1 and a BYPASS=0 core in lockstep against a reference model.
module tb_reg_alu_pipe;
    import reg_alu_pkg::*;

    localparam int W = 16;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_alu_pipe_if #(.WIDTH(W), .NREGS(N)) bus_b ();
    reg_alu_pipe_if #(.WIDTH(W), .NREGS(N)) bus_n ();

    reg_alu_pipe #(.WIDTH(W), .NREGS(N), .BYPASS(1)) u_byp (.clk(clk), .reset(reset), .bus(bus_b));
    reg_alu_pipe #(.WIDTH(W), .NREGS(N), .BYPASS(0)) u_nob (.clk(clk), .reset(reset), .bus(bus_n));

    typedef struct packed {
        logic [31:0]  due;
        logic         v;
        logic [W-1:0] r0;
        logic         c0;
        logic         z0;
        logic [W-1:0] r1;
        logic         c1;
        logic         z1;
    } res_t;

    typedef struct packed {
        logic [31:0]  due;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
    } opd_t;

    res_t exp_q[$];
    opd_t opd_q[$];

    // Model state per core (0 = bypassing, 1 = not): arch is the program-order register
    // state; prev is that state as it stood one edge earlier, which is what a core
    // without forwarding shows to the next op.
    logic [W-1:0] arch[2][N];
    logic [W-1:0] prev[2][N];
    logic [W-1:0] last_res[2];
    logic         last_c[2];
    logic         last_z[2];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_alu(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        case (o)
            OP_ADD:  return {(ua + ub) >= (32'd1 << W), W'(ua + ub)};
            OP_SUB:  return {ua >= ub, W'(ua - ub)};
            OP_AND:  return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
                arch[m][i] = '0;
                prev[m][i] = '0;
            end
            last_res[m] = '0;
            last_c[m]   = 1'b0;
            last_z[m]   = 1'b0;
        end
    endtask

    task automatic set_bus(input logic v, input logic s, input logic w, input logic [1:0] o,
                           input int ra, input int rb, input int wa, input logic [W-1:0] din);
        bus_b.valid_in = v;  bus_n.valid_in = v;
        bus_b.sel = s;       bus_n.sel = s;
        bus_b.wr = w;        bus_n.wr = w;
        bus_b.op = o;        bus_n.op = o;
        bus_b.rd_addr_a = 3'(ra);  bus_n.rd_addr_a = 3'(ra);
        bus_b.rd_addr_b = 3'(rb);  bus_n.rd_addr_b = 3'(rb);
        bus_b.wr_addr = 3'(wa);    bus_n.wr_addr = 3'(wa);
        bus_b.d_in = din;    bus_n.d_in = din;
    endtask

    // Drives one cycle of inputs and queues what both cores must show: operands now,
    // result/flags after the coming edge.
    task automatic drive(input logic v, input logic s, input logic w, input logic [1:0] o,
                         input int ra, input int rb, input int wa, input logic [W-1:0] din);
        opd_t         oe;
        res_t         re;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        set_bus(v, s, w, o, ra, rb, wa, din);
        oe = '0;
        re = '0;
        oe.due = cyc;
        re.due = cyc + 1;
        re.v   = v;
        for (int m = 0; m < 2; m++) begin
            a = (m == 0) ? arch[m][ra] : prev[m][ra];
            b = (m == 0) ? arch[m][rb] : prev[m][rb];
            if (m == 0) begin oe.a0 = a; oe.b0 = b; end
            else        begin oe.a1 = a; oe.b1 = b; end
            for (int i = 0; i < N; i++) prev[m][i] = arch[m][i];
            if (v) begin
                if (s) {c, r} = ref_alu(o, a, b);
                else   begin c = 1'b0; r = din; end
                last_res[m] = r;
                last_c[m]   = c;
                last_z[m]   = (r == '0);
                if (w) arch[m][wa] = r;
            end
        end
        re.r0 = last_res[0]; re.c0 = last_c[0]; re.z0 = last_z[0];
        re.r1 = last_res[1]; re.c1 = last_c[1]; re.z1 = last_z[1];
        opd_q.push_back(oe);
        exp_q.push_back(re);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic w, input logic [1:0] o,
                         input int ra, input int rb, input int wa, input logic [W-1:0] din);
        drive(1'b1, s, w, o, ra, rb, wa, din);
        step();
    endtask

    task automatic idle(input int ra, input int rb);
        drive(1'b0, 1'b0, 1'b0, OP_ADD, ra, rb, 0, '0);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk1("rst.byp.result_valid", bus_b.result_valid, 1'b0);
        chk ("rst.byp.result", bus_b.result, '0);
        chk1("rst.byp.cout", bus_b.cout, 1'b0);
        chk1("rst.byp.zero", bus_b.zero, 1'b0);
        chk1("rst.nob.result_valid", bus_n.result_valid, 1'b0);
        chk ("rst.nob.result", bus_n.result, '0);
        exp_q.delete();
        opd_q.delete();
        model_clear();
        set_bus(1'b0, 1'b0, 1'b0, OP_ADD, 0, 0, 0, '0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        step();
    endtask

    // Monitor: pops whatever is due this cycle and compares both cores.
    always @(negedge clk) begin
        if (!reset) begin
            if (opd_q.size() > 0 && opd_q[0].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL opd.missed: got due %0d expected %0d", opd_q[0].due, cyc);
                void'(opd_q.pop_front());
            end else if (opd_q.size() > 0 && opd_q[0].due == cyc) begin
                opd_t oe;
                oe = opd_q.pop_front();
                chk("byp.d_out_a", bus_b.d_out_a, oe.a0);
                chk("byp.d_out_b", bus_b.d_out_b, oe.b0);
                chk("nob.d_out_a", bus_n.d_out_a, oe.a1);
                chk("nob.d_out_b", bus_n.d_out_b, oe.b1);
            end
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL res.missed: got due %0d expected %0d", exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                res_t re;
                re = exp_q.pop_front();
                chk1("byp.result_valid", bus_b.result_valid, re.v);
                chk ("byp.result", bus_b.result, re.r0);
                chk1("byp.cout", bus_b.cout, re.c0);
                chk1("byp.zero", bus_b.zero, re.z0);
                chk1("nob.result_valid", bus_n.result_valid, re.v);
                chk ("nob.result", bus_n.result, re.r1);
                chk1("nob.cout", bus_n.cout, re.c1);
                chk1("nob.zero", bus_n.zero, re.z1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] din;
        model_clear();
        set_bus(1'b0, 1'b0, 1'b0, OP_ADD, 0, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk1("init.byp.result_valid", bus_b.result_valid, 1'b0);
        chk ("init.byp.result", bus_b.result, '0);
        reset = 1'b0;
        step();

        // Reset while EX holds a pending write to r3.
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 3, 16'h1234);
        do_reset();
        drive(1'b0, 1'b0, 1'b0, OP_ADD, 3, 3, 0, '0);
        #1;
        chk("rst.r3.byp", bus_b.d_out_a, 16'h0000);
        chk("rst.r3.nob", bus_n.d_out_a, 16'h0000);
        step();

        // Loads, then ADD r1,r2 -> r4.
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 1, 16'h0005);
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 2, 16'h0003);
        idle(0, 0);
        issue(1'b1, 1'b1, OP_ADD, 1, 2, 4, '0);
        chk ("add.result", bus_b.result, 16'h0008);
        chk1("add.cout", bus_b.cout, 1'b0);
        chk1("add.zero", bus_b.zero, 1'b0);
        idle(0, 0);
        drive(1'b0, 1'b0, 1'b0, OP_ADD, 4, 4, 0, '0);
        #1;
        chk("add.r4", bus_b.d_out_a, 16'h0008);
        step();

        // Back-to-back RAW on r1.
        issue(1'b1, 1'b1, OP_ADD, 1, 2, 1, '0);
        drive(1'b1, 1'b1, 1'b1, OP_ADD, 1, 2, 5, '0);
        #1;
        chk("raw.byp.d_out_a", bus_b.d_out_a, 16'h0008);
        chk("raw.nob.d_out_a", bus_n.d_out_a, 16'h0005);
        step();
        idle(0, 0);
        drive(1'b0, 1'b0, 1'b0, OP_ADD, 5, 5, 0, '0);
        #1;
        chk("raw.byp.r5", bus_b.d_out_a, 16'h000B);
        chk("raw.nob.r5", bus_n.d_out_a, 16'h0008);
        step();

        // Wrap-around ADD and borrowing SUB.
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 6, 16'hFFFF);
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 7, 16'h0001);
        idle(0, 0);
        issue(1'b1, 1'b1, OP_ADD, 6, 7, 0, '0);
        chk ("wrap.result", bus_b.result, 16'h0000);
        chk1("wrap.cout", bus_b.cout, 1'b1);
        chk1("wrap.zero", bus_b.zero, 1'b1);
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 6, 16'h0003);
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 7, 16'h0005);
        idle(0, 0);
        issue(1'b1, 1'b1, OP_SUB, 6, 7, 0, '0);
        chk ("sub.result", bus_b.result, 16'hFFFE);
        chk1("sub.cout", bus_b.cout, 1'b0);
        chk1("sub.zero", bus_b.zero, 1'b0);

        // Logic ops, a compare-style wr=0 op, then an idle gap with wr asserted.
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 6, 16'hF0F0);
        issue(1'b0, 1'b1, OP_ADD, 0, 0, 7, 16'h0FF0);
        idle(0, 0);
        issue(1'b1, 1'b1, OP_AND, 6, 7, 0, '0);
        chk("and.result", bus_b.result, 16'h00F0);
        issue(1'b1, 1'b1, OP_OR, 6, 7, 2, '0);
        chk("or.result", bus_b.result, 16'hFFF0);
        issue(1'b1, 1'b0, OP_SUB, 6, 6, 4, '0);
        chk ("cmp.result", bus_b.result, 16'h0000);
        chk1("cmp.cout", bus_b.cout, 1'b1);
        chk1("cmp.zero", bus_b.zero, 1'b1);
        drive(1'b0, 1'b0, 1'b1, OP_ADD, 0, 0, 3, 16'hABCD);
        step();
        chk1("gap.result_valid", bus_b.result_valid, 1'b0);
        chk ("gap.result", bus_b.result, 16'h0000);
        chk1("gap.cout", bus_b.cout, 1'b1);
        chk1("gap.zero", bus_b.zero, 1'b1);
        drive(1'b0, 1'b0, 1'b0, OP_ADD, 4, 3, 0, '0);
        #1;
        chk("cmp.r4", bus_b.d_out_a, 16'h0008);
        chk("gap.r3", bus_b.d_out_b, 16'h0000);
        step();

        // Random traffic, with one asynchronous reset in the middle.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            case ($urandom_range(0, 3))
                0:       din = '0;
                1:       din = '1;
                2:       din = 16'h8000;
                default: din = W'($urandom);
            endcase
            drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                  $urandom_range(0, N - 1), din);
            step();
        end

        // Read every register back once the pipe has drained.
        idle(0, 0);
        for (int i = 0; i < N; i++) idle(i, N - 1 - i);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0 || opd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d entries expected 0/0", exp_q.size(), opd_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
